vga_frame_rx: RTL and testbench

Receiver-side check for the VGA timing/pixel stream produced by the display path (hs, vs, rdn, r/g/b).
- Samples the stream at the pixel strobe.
- Reconstructs row/col from the sync edges and measures line/frame totals.
- Locks onto a stable timing and reports sticky timing errors.
- Computes a per-frame pixel signature, so on-board self-test and simulation can check rendered frames (map, ball, gameover/victory screens) without a monitor.

---
 rtl/vga_frame_rx_pkg.sv | 29 ++
 rtl/vga_sync_edge.sv | 41 ++++
 rtl/vga_frame_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_frame_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_rx_pkg.sv
// rtl/vga_frame_rx_pkg.sv - 640x480@60 timing constants, receiver FSM states, signature step
package vga_frame_rx_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_OFS    = VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_OFS    = VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    // Rotate-left-by-one then fold the 12-bit pixel into the low bits.
    function automatic logic [15:0] sig_step(input logic [15:0] sum, input logic [11:0] pix);
        return {sum[14:0], sum[15]} ^ {4'h0, pix};
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - pix_en sampler with previous-sample sync registers and fall pulses
module vga_sync_edge
    import vga_frame_rx_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        rdn,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        smp,
    output logic        hs_fall,
    output logic        vs_fall,
    output logic        rdn_s,
    output logic [11:0] pix_s
);

    logic hs_q;
    logic vs_q;

    // Previous sample idles high so a low sync right after reset reads as a fall.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (pix_en) begin
            hs_q <= hs;
            vs_q <= vs;
        end
    end

    assign smp     = pix_en;
    assign hs_fall = pix_en & hs_q & ~hs;
    assign vs_fall = pix_en & vs_q & ~vs;
    assign rdn_s   = rdn;
    assign pix_s   = {r, g, b};

endmodule

// File: rtl/vga_frame_rx.sv
// rtl/vga_frame_rx.sv - VGA stream receiver: position recovery, timing lock, error flags, frame signature
module vga_frame_rx
    import vga_frame_rx_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int H_OFS    = VGA_H_OFS,
    parameter int V_OFS    = VGA_V_OFS,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        rdn,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [8:0]  row,
    output logic [9:0]  col,
    output logic [11:0] pixel,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  frame_cnt,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic        err_h,
    output logic        err_v,
    output logic        err_active
);

    localparam logic [11:0] H_TOT_L = 12'(H_TOTAL);
    localparam logic [11:0] V_TOT_L = 12'(V_TOTAL);
    localparam logic [10:0] H_LO    = 11'(H_OFS);
    localparam logic [10:0] H_HI    = 11'(H_OFS + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_OFS);
    localparam logic [10:0] V_HI    = 11'(V_OFS + V_ACTIVE);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    rx_state_e   state;
    rx_state_e   state_n;

    logic        smp;
    logic        hs_fall;
    logic        vs_fall;
    logic        rdn_s;
    logic [11:0] pix_s;

    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [10:0] hcnt_n;
    logic [10:0] vcnt_n;
    logic [11:0] h_len;
    logic [11:0] v_len;
    logic        hs_seen;
    logic        line_bad;
    logic        line_bad_n;
    logic [15:0] sum;
    logic [15:0] sum_n;

    logic        h_mis;
    logic        v_mis;
    logic        in_win;
    logic        capture;
    logic        frame_ok;
    logic        set_err_h;
    logic        set_err_v;
    logic        set_err_active;

    vga_sync_edge u_sync_edge (
        .clk     (clk),
        .clrn    (clrn),
        .pix_en  (pix_en),
        .hs      (hs),
        .vs      (vs),
        .rdn     (rdn),
        .r       (r),
        .g       (g),
        .b       (b),
        .smp     (smp),
        .hs_fall (hs_fall),
        .vs_fall (vs_fall),
        .rdn_s   (rdn_s),
        .pix_s   (pix_s)
    );

    // Counter values that apply to the current sample; vs is handled before hs.
    always_comb begin
        hcnt_n     = hcnt;
        vcnt_n     = vcnt;
        h_len      = {1'b0, hcnt} + 12'd1;
        v_len      = {1'b0, vcnt} + 12'd1;
        if (hs_fall) begin
            hcnt_n = 11'd0;
        end else if (hcnt != CNT_MAX) begin
            hcnt_n = hcnt + 11'd1;
        end
        if (vs_fall) begin
            vcnt_n = 11'd0;
        end else if (hs_fall && (vcnt != CNT_MAX)) begin
            vcnt_n = vcnt + 11'd1;
        end
        h_mis      = hs_fall & hs_seen & (h_len != H_TOT_L);
        v_mis      = vs_fall & (v_len != V_TOT_L);
        in_win     = (hcnt_n >= H_LO) && (hcnt_n < H_HI) &&
                     (vcnt_n >= V_LO) && (vcnt_n < V_HI);
        capture    = smp & ~rdn_s & (state != ST_SEARCH);
        line_bad_n = vs_fall ? 1'b0 : (line_bad | h_mis);
        sum_n      = vs_fall ? 16'h0000 : sum;
        if (capture) begin
            sum_n = sig_step(sum_n, pix_s);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_SEARCH;
        end else begin
            state <= state_n;
        end
    end

    // The vs fall that closes a frame also carries the hs fall measuring its last line.
    always_comb begin
        state_n        = state;
        frame_ok       = 1'b0;
        set_err_h      = 1'b0;
        set_err_v      = 1'b0;
        set_err_active = 1'b0;
        if (smp) begin
            case (state)
                ST_SEARCH: begin
                    if (vs_fall) begin
                        state_n = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (vs_fall && !v_mis && !h_mis && !line_bad) begin
                        state_n = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    set_err_h      = h_mis;
                    set_err_v      = v_mis;
                    set_err_active = (rdn_s == in_win);
                    if (h_mis || v_mis) begin
                        state_n = ST_ALIGN;
                    end else if (vs_fall) begin
                        frame_ok = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_SEARCH;
                end
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hcnt         <= 11'd0;
            vcnt         <= 11'd0;
            hs_seen      <= 1'b0;
            line_bad     <= 1'b0;
            sum          <= 16'h0000;
            pix_valid    <= 1'b0;
            row          <= 9'd0;
            col          <= 10'd0;
            pixel        <= 12'h000;
            frame_done   <= 1'b0;
            frame_sum    <= 16'h0000;
            frame_cnt    <= 8'd0;
            h_total_meas <= 11'd0;
            v_total_meas <= 11'd0;
            err_h        <= 1'b0;
            err_v        <= 1'b0;
            err_active   <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (smp) begin
                hcnt     <= hcnt_n;
                vcnt     <= vcnt_n;
                line_bad <= line_bad_n;
                sum      <= sum_n;
                if (hs_fall) begin
                    hs_seen <= 1'b1;
                    if (hs_seen) begin
                        h_total_meas <= h_len[10:0];
                    end
                end
                if (vs_fall) begin
                    v_total_meas <= v_len[10:0];
                end
                if (capture) begin
                    pix_valid <= 1'b1;
                    row       <= 9'(vcnt_n - V_LO);
                    col       <= 10'(hcnt_n - H_LO);
                    pixel     <= pix_s;
                end
                if (frame_ok) begin
                    frame_done <= 1'b1;
                    frame_sum  <= sum;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
                if (set_err_h) begin
                    err_h <= 1'b1;
                end
                if (set_err_v) begin
                    err_v <= 1'b1;
                end
                if (set_err_active) begin
                    err_active <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_rx.sv
// tb/tb_vga_frame_rx.sv - scoreboard bench for vga_frame_rx on a reduced raster
module tb_vga_frame_rx;

    localparam int HT  = 12;
    localparam int VT  = 8;
    localparam int HO  = 3;
    localparam int VO  = 2;
    localparam int HA  = 8;
    localparam int VA  = 5;
    localparam int HSW = 2;
    localparam int VSW = 1;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        pix_en = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        rdn = 1'b1;
    logic [3:0]  r = 4'h0;
    logic [3:0]  g = 4'h0;
    logic [3:0]  b = 4'h0;
    logic        pix_valid;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] pixel;
    logic        locked;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [7:0]  frame_cnt;
    logic [10:0] h_total_meas;
    logic [10:0] v_total_meas;
    logic        err_h;
    logic        err_v;
    logic        err_active;

    vga_frame_rx #(
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_OFS    (HO),
        .V_OFS    (VO),
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .pix_en       (pix_en),
        .hs           (hs),
        .vs           (vs),
        .rdn          (rdn),
        .r            (r),
        .g            (g),
        .b            (b),
        .pix_valid    (pix_valid),
        .row          (row),
        .col          (col),
        .pixel        (pixel),
        .locked       (locked),
        .frame_done   (frame_done),
        .frame_sum    (frame_sum),
        .frame_cnt    (frame_cnt),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas),
        .err_h        (err_h),
        .err_v        (err_v),
        .err_active   (err_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  row;
        logic [9:0]  col;
        logic [11:0] pix;
    } pix_t;

    typedef struct packed {
        logic [15:0] sum;
        logic [7:0]  cnt;
    } frm_t;

    pix_t        pix_q[$];
    frm_t        frm_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        capturing = 1'b0;
    logic [15:0] exp_sum = 16'h0000;
    logic [7:0]  exp_cnt = 8'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] sig(input logic [15:0] s, input logic [11:0] p);
        return {s[14:0], s[15]} ^ {4'h0, p};
    endfunction

    function automatic logic [11:0] pat(input int kind, input int prow, input int pcol);
        case (kind)
            0:       return 12'h666;
            1:       return (prow == 0 && pcol == 0) ? 12'hFFF : 12'h000;
            default: return 12'(prow * 37 + pcol * 5 + 1);
        endcase
    endfunction

    task automatic check_zero(input string t);
        chk({t, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({t, "_row"}, 32'(row), 32'd0);
        chk({t, "_col"}, 32'(col), 32'd0);
        chk({t, "_pixel"}, 32'(pixel), 32'd0);
        chk({t, "_locked"}, 32'(locked), 32'd0);
        chk({t, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({t, "_frame_sum"}, 32'(frame_sum), 32'd0);
        chk({t, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({t, "_h_total_meas"}, 32'(h_total_meas), 32'd0);
        chk({t, "_v_total_meas"}, 32'(v_total_meas), 32'd0);
        chk({t, "_errs"}, 32'({err_h, err_v, err_active}), 32'd0);
    endtask

    task automatic strobe(input int gap, input logic hs_v, input logic vs_v,
                          input logic rdn_v, input logic [11:0] p);
        int n;
        n = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (n) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
        @(negedge clk);
        hs        = hs_v;
        vs        = vs_v;
        rdn       = rdn_v;
        {r, g, b} = p;
        pix_en    = 1'b1;
    endtask

    task automatic settle();
        repeat (2) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        pix_en = 1'b0;
        clrn   = 1'b0;
        #1;
        check_zero("midrst");
        chk("midrst_pix_q", 32'(pix_q.size()), 32'd0);
        chk("midrst_frm_q", 32'(frm_q.size()), 32'd0);
        capturing = 1'b0;
        exp_cnt   = 8'd0;
        exp_sum   = 16'h0000;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
    endtask

    // One raster frame starting with the combined vs/hs fall.
    task automatic send_frame(input int kind, input bit done_exp, input int gap,
                              input int bad_line, input int early_row, input int rst_line);
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == bad_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic        act;
                logic [11:0] p;
                pix_t        e;
                if (l == rst_line && h == 0) mid_reset();
                act = ((l >= VO) && (l < VO + VA) && (h >= HO) && (h < HO + HA)) ||
                      ((l == VO + early_row) && (h == HO - 1));
                p = act ? pat(kind, l - VO, h - HO) : 12'h000;
                if (l == 0 && h == 0) begin
                    if (done_exp) begin
                        exp_cnt = exp_cnt + 8'd1;
                        frm_q.push_back({exp_sum, exp_cnt});
                    end
                    exp_sum   = 16'h0000;
                    capturing = 1'b1;
                end
                if (act && capturing) begin
                    exp_sum = sig(exp_sum, p);
                    e.row   = 9'(l - VO);
                    e.col   = 10'(h - HO);
                    e.pix   = p;
                    pix_q.push_back(e);
                end
                strobe(gap, (h >= HSW), (l >= VSW), ~act, p);
            end
        end
    endtask

    initial begin : monitor
        pix_t e;
        frm_t f;
        forever begin
            @(negedge clk);
            if (pix_valid === 1'b1) begin
                if (pix_q.size() == 0) begin
                    chk("pix_valid_unexpected", 32'(pix_valid), 32'd0);
                end else begin
                    e = pix_q.pop_front();
                    chk("row", 32'(row), 32'(e.row));
                    chk("col", 32'(col), 32'(e.col));
                    chk("pixel", 32'(pixel), 32'(e.pix));
                end
            end
            if (frame_done === 1'b1) begin
                if (frm_q.size() == 0) begin
                    chk("frame_done_unexpected", 32'(frame_done), 32'd0);
                end else begin
                    f = frm_q.pop_front();
                    chk("frame_sum", 32'(frame_sum), 32'(f.sum));
                    chk("frame_cnt", 32'(frame_cnt), 32'(f.cnt));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(0, 1'b0, 3, -1, -99, -1);
        settle();
        chk("locked_after_vs1", 32'(locked), 32'd0);
        send_frame(0, 1'b0, 3, -1, -99, -1);
        settle();
        chk("locked_after_vs2", 32'(locked), 32'd1);
        chk("h_total_meas", 32'(h_total_meas), 32'(HT));
        chk("v_total_meas", 32'(v_total_meas), 32'(VT));
        send_frame(1, 1'b1, 3, -1, -99, -1);
        send_frame(0, 1'b1, 3, 4, -99, -1);
        settle();
        chk("locked_after_short_line", 32'(locked), 32'd0);
        chk("err_h_set", 32'(err_h), 32'd1);
        send_frame(0, 1'b0, 3, -1, -99, -1);
        settle();
        chk("locked_after_bad_frame_end", 32'(locked), 32'd0);
        send_frame(0, 1'b0, 3, -1, -99, -1);
        settle();
        chk("relocked", 32'(locked), 32'd1);
        chk("err_h_sticky", 32'(err_h), 32'd1);

        send_frame(2, 1'b1, 3, -1, 2, -1);
        settle();
        chk("err_active_set", 32'(err_active), 32'd1);
        chk("locked_kept_on_rdn_err", 32'(locked), 32'd1);

        send_frame(2, 1'b1, 3, -1, -99, VO + 3);
        settle();
        chk("locked_after_midrst", 32'(locked), 32'd0);
        send_frame(2, 1'b0, 3, -1, -99, -1);
        settle();
        chk("locked_after_rst_vs1", 32'(locked), 32'd0);
        send_frame(2, 1'b0, 3, -1, -99, -1);
        settle();
        chk("locked_after_rst_vs2", 32'(locked), 32'd1);

        send_frame(2, 1'b1, -1, -1, -99, -1);
        send_frame(1, 1'b1, -1, -1, -99, -1);
        for (int i = 0; i < 256; i++) begin
            send_frame(2, 1'b1, 0, -1, -99, -1);
        end
        settle();
        repeat (4) @(negedge clk);
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
        chk("frm_q_drained", 32'(frm_q.size()), 32'd0);
        chk("frame_cnt_final", 32'(frame_cnt), 32'(exp_cnt));
        chk("errs_after_reset", 32'({err_h, err_v, err_active}), 32'd0);
        chk("locked_final", 32'(locked), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
